// File: rtl/l2_rr_arbiter_if.sv
// Bus bundle between the L1 clients, the L2 arbiter and the shared L2 cache.
// master = arbiter view, slave = client/L2 environment view.
interface l2_rr_arbiter_if #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128
);
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address;
    logic [NUM_CLIENTS-1:0]            cl_read;
    logic [NUM_CLIENTS-1:0]            cl_write;
    logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_wdata;
    logic [LINE_WIDTH-1:0]             cl_rdata;
    logic [NUM_CLIENTS-1:0]            cl_resp;
    logic [ADDR_WIDTH-1:0]             L2_mem_address;
    logic                              L2_mem_read;
    logic                              L2_mem_write;
    logic [LINE_WIDTH-1:0]             L2_mem_wdata;
    logic                              L2_mem_resp;
    logic [LINE_WIDTH-1:0]             L2_mem_rdata;

    modport master (
        input  cl_address, cl_read, cl_write, cl_wdata, L2_mem_resp, L2_mem_rdata,
        output cl_rdata, cl_resp, L2_mem_address, L2_mem_read, L2_mem_write, L2_mem_wdata
    );

    modport slave (
        output cl_address, cl_read, cl_write, cl_wdata, L2_mem_resp, L2_mem_rdata,
        input  cl_rdata, cl_resp, L2_mem_address, L2_mem_read, L2_mem_write, L2_mem_wdata
    );
endinterface

// File: rtl/l2_rr_arbiter.sv
// Round-robin N-client arbiter in front of the shared L2: latches the winner's
// request, holds it to L2 until L2_mem_resp, and returns the response to the winner.
module l2_rr_arbiter #(
    parameter int unsigned  NUM_CLIENTS = 2,
    parameter int unsigned  ADDR_WIDTH  = 16,
    parameter int unsigned  LINE_WIDTH  = 128,
    localparam int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_rr_arbiter_if.master  bus,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       next_ptr;
    logic                   found;
    logic [NUM_CLIENTS-1:0] req;
    logic                   any_req;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;
    logic                   rd_q;
    logic                   wr_q;
    logic [NUM_CLIENTS-1:0] resp_vec;

    assign req     = bus.cl_read | bus.cl_write;
    assign any_req = |req;

    // First requester at or after rr_ptr, scanning modulo NUM_CLIENTS.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_CLIENTS);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_id == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        resp_vec = '0;
        if (state == BUSY && bus.L2_mem_resp)
            resp_vec[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        addr_q   <= bus.cl_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q  <= bus.cl_wdata[winner*LINE_WIDTH +: LINE_WIDTH];
                        wr_q     <= bus.cl_write[winner];
                        rd_q     <= ~bus.cl_write[winner];
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.L2_mem_resp) begin
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= DRAIN;
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy               = (state != IDLE);
    assign bus.cl_resp        = resp_vec;
    assign bus.cl_rdata       = bus.L2_mem_rdata;
    assign bus.L2_mem_address = addr_q;
    assign bus.L2_mem_wdata   = wdata_q;
    assign bus.L2_mem_read    = rd_q;
    assign bus.L2_mem_write   = wr_q;
endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Directed bench for l2_rr_arbiter with 2-, 4- and 3-client instances on one clock.
module tb_l2_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    localparam logic [127:0] WDATA = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] RDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    l2_rr_arbiter_if #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) if2 ();
    l2_rr_arbiter_if #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) if4 ();
    l2_rr_arbiter_if #(.NUM_CLIENTS(3), .ADDR_WIDTH(16), .LINE_WIDTH(128)) if3 ();

    logic [0:0] g2;
    logic [1:0] g4;
    logic [1:0] g3;
    logic       b2, b4, b3;

    l2_rr_arbiter #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .grant_id(g2), .busy(b2));
    l2_rr_arbiter #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .grant_id(g4), .busy(b4));
    l2_rr_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .grant_id(g3), .busy(b3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        if2.cl_address = '0; if2.cl_read = '0; if2.cl_write = '0; if2.cl_wdata = '0;
        if2.L2_mem_resp = 1'b0; if2.L2_mem_rdata = '0;
        if4.cl_address = '0; if4.cl_read = '0; if4.cl_write = '0; if4.cl_wdata = '0;
        if4.L2_mem_resp = 1'b0; if4.L2_mem_rdata = '0;
        if3.cl_address = '0; if3.cl_read = '0; if3.cl_write = '0; if3.cl_wdata = '0;
        if3.L2_mem_resp = 1'b0; if3.L2_mem_rdata = '0;
        tick();
        tick();
        chk("rst_read",  128'(if2.L2_mem_read), 128'(0));
        chk("rst_write", 128'(if2.L2_mem_write), 128'(0));
        chk("rst_resp",  128'(if2.cl_resp), 128'(0));
        chk("rst_busy",  128'(b2), 128'(0));
        chk("rst_grant", 128'(g2), 128'(0));
        chk("rst_addr",  128'(if2.L2_mem_address), 128'(0));
        rst_n = 1'b1;

        // Single client 1 read, L2 answers in cycle 4
        if2.cl_address = {16'h1230, 16'h0000};
        if2.cl_read    = 2'b10;
        tick();
        chk("A_read_c1", 128'(if2.L2_mem_read), 128'(1));
        chk("A_addr",    128'(if2.L2_mem_address), 128'(16'h1230));
        chk("A_grant",   128'(g2), 128'(1));
        chk("A_busy",    128'(b2), 128'(1));
        tick();
        tick();
        chk("A_read_c3", 128'(if2.L2_mem_read), 128'(1));
        chk("A_resp_c3", 128'(if2.cl_resp), 128'(0));
        tick();
        if2.L2_mem_rdata = RDATA;
        if2.L2_mem_resp  = 1'b1;
        #1;
        chk("A_resp_c4", 128'(if2.cl_resp), 128'(2'b10));
        chk("A_rdata",   if2.cl_rdata, RDATA);
        chk("A_read_c4", 128'(if2.L2_mem_read), 128'(1));
        tick();
        if2.L2_mem_resp = 1'b0;
        if2.cl_read     = 2'b00;
        #1;
        chk("A_read_c5", 128'(if2.L2_mem_read), 128'(0));
        chk("A_resp_c5", 128'(if2.cl_resp), 128'(0));
        chk("A_drain",   128'(b2), 128'(1));
        tick();
        chk("A_idle",    128'(b2), 128'(0));

        // Client 0 read+write (treated as write); client 1 arrives during BUSY
        if2.cl_address = {16'h2220, 16'h4000};
        if2.cl_wdata   = {128'h0, WDATA};
        if2.cl_read    = 2'b01;
        if2.cl_write   = 2'b01;
        tick();
        chk("B_write", 128'(if2.L2_mem_write), 128'(1));
        chk("B_read",  128'(if2.L2_mem_read), 128'(0));
        chk("B_wdata", if2.L2_mem_wdata, WDATA);
        chk("B_grant", 128'(g2), 128'(0));
        if2.cl_wdata   = '0;
        if2.cl_address = {16'h2220, 16'hFFFF};
        if2.cl_read    = 2'b11;
        tick();
        chk("B_wdata_hold", if2.L2_mem_wdata, WDATA);
        chk("B_addr_hold",  128'(if2.L2_mem_address), 128'(16'h4000));
        chk("B_grant_hold", 128'(g2), 128'(0));
        if2.L2_mem_resp = 1'b1;
        #1;
        chk("B_resp", 128'(if2.cl_resp), 128'(2'b01));
        tick();
        if2.L2_mem_resp = 1'b0;
        chk("B_drain_wr",    128'(if2.L2_mem_write), 128'(0));
        chk("B_drain_grant", 128'(g2), 128'(0));
        tick();
        tick();
        chk("L_grant", 128'(g2), 128'(1));
        chk("L_read",  128'(if2.L2_mem_read), 128'(1));
        chk("L_write", 128'(if2.L2_mem_write), 128'(0));
        chk("L_addr",  128'(if2.L2_mem_address), 128'(16'h2220));
        if2.L2_mem_resp = 1'b1;
        #1;
        chk("L_resp", 128'(if2.cl_resp), 128'(2'b10));
        tick();
        if2.cl_read = 2'b01;
        #1;
        chk("L_drain_spurious", 128'(if2.cl_resp), 128'(0));
        if2.L2_mem_resp = 1'b0;
        tick();
        tick();
        chk("L_regrant",     128'(g2), 128'(0));
        chk("L_regrant_wr",  128'(if2.L2_mem_write), 128'(1));
        chk("L_regrant_dat", if2.L2_mem_wdata, 128'(0));
        if2.L2_mem_resp = 1'b1;
        tick();
        if2.L2_mem_resp = 1'b0;
        if2.cl_read     = 2'b00;
        if2.cl_write    = 2'b00;
        tick();
        tick();

        // Four clients requesting continuously
        if4.cl_address = {16'hA300, 16'hA200, 16'hA100, 16'hA000};
        if4.cl_read    = 4'hF;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("C_grant", 128'(g4), 128'(exp_order[t]));
            chk("C_addr",  128'(if4.L2_mem_address), 128'(32'hA000 + exp_order[t] * 256));
            chk("C_read",  128'(if4.L2_mem_read), 128'(1));
            if4.L2_mem_resp = 1'b1;
            #1;
            chk("C_resp", 128'(if4.cl_resp), 128'(4'b0001 << exp_order[t]));
            tick();
            if4.L2_mem_resp = 1'b0;
            #1;
            chk("C_drain_read", 128'(if4.L2_mem_read), 128'(0));
            chk("C_drain_resp", 128'(if4.cl_resp), 128'(0));
            tick();
            chk("C_idle", 128'(b4), 128'(0));
        end

        // Reset in the middle of a BUSY transaction
        tick();
        chk("D_pre_grant", 128'(g4), 128'(2));
        if4.L2_mem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("D_read",  128'(if4.L2_mem_read), 128'(0));
        chk("D_write", 128'(if4.L2_mem_write), 128'(0));
        chk("D_resp",  128'(if4.cl_resp), 128'(0));
        chk("D_busy",  128'(b4), 128'(0));
        chk("D_grant", 128'(g4), 128'(0));
        chk("D_addr",  128'(if4.L2_mem_address), 128'(0));
        rst_n = 1'b1;
        if4.L2_mem_resp = 1'b0;
        tick();
        chk("D_regrant", 128'(g4), 128'(0));
        chk("D_reread",  128'(if4.L2_mem_read), 128'(1));
        chk("D_readdr",  128'(if4.L2_mem_address), 128'(16'hA000));
        if4.L2_mem_resp = 1'b1;
        tick();
        if4.L2_mem_resp = 1'b0;
        if4.cl_read     = 4'h0;
        tick();
        tick();

        // Three clients: spurious response in IDLE, pointer wrap 2 -> 0
        if3.L2_mem_resp = 1'b1;
        #1;
        chk("S_resp", 128'(if3.cl_resp), 128'(0));
        tick();
        chk("S_busy", 128'(b3), 128'(0));
        chk("S_read", 128'(if3.L2_mem_read), 128'(0));
        if3.L2_mem_resp = 1'b0;
        if3.cl_address  = {16'hC200, 16'hC100, 16'hC000};
        if3.cl_read     = 3'b100;
        tick();
        chk("W_grant2", 128'(g3), 128'(2));
        chk("W_addr2",  128'(if3.L2_mem_address), 128'(16'hC200));
        if3.L2_mem_resp = 1'b1;
        #1;
        chk("W_resp2", 128'(if3.cl_resp), 128'(3'b100));
        tick();
        if3.L2_mem_resp = 1'b0;
        if3.cl_read     = 3'b111;
        tick();
        tick();
        chk("W_wrap_grant", 128'(g3), 128'(0));
        chk("W_wrap_addr",  128'(if3.L2_mem_address), 128'(16'hC000));
        if3.L2_mem_resp = 1'b1;
        #1;
        chk("W_resp0", 128'(if3.cl_resp), 128'(3'b001));
        tick();
        if3.L2_mem_resp = 1'b0;
        tick();
        tick();
        chk("W_grant1", 128'(g3), 128'(1));
        if3.L2_mem_resp = 1'b1;
        #1;
        chk("W_resp1", 128'(if3.cl_resp), 128'(3'b010));
        tick();
        if3.L2_mem_resp = 1'b0;
        if3.cl_read     = 3'b000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
